// File: rtl/cpu_grp1_core_if.sv
// Memory bus and trace signals between cpu_grp1_core and its memory / debug logic.
interface cpu_grp1_core_if;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic [15:0] addr;
    logic        we;
    logic        sync;
    logic [7:0]  a_out;
    logic [7:0]  p_out;

    modport master (
        input  d_in,
        output d_out, addr, we, sync, a_out, p_out
    );

    modport slave (
        output d_in,
        input  d_out, addr, we, sync, a_out, p_out
    );
endinterface

// File: rtl/cpu_grp1_core.sv
// Multi-cycle 6502-style core: cc=01 group in immediate / zero-page / absolute modes,
// CLC/SEC, and a 2-cycle NOP for every other opcode.
module cpu_grp1_core #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  RESET_P  = 8'h24,
    parameter logic [7:0]  RESET_A  = 8'h00
) (
    input logic             clk,
    input logic             rst,
    cpu_grp1_core_if.master bus
);
    localparam int unsigned P_N = 7;
    localparam int unsigned P_V = 6;
    localparam int unsigned P_Z = 1;
    localparam int unsigned P_C = 0;

    localparam logic [2:0] OP_ORA = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_EOR = 3'd2;
    localparam logic [2:0] OP_ADC = 3'd3;
    localparam logic [2:0] OP_STA = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_SBC = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IMPL  = 3'd1,
        S_IMM   = 3'd2,
        S_ZP1   = 3'd3,
        S_ABS1  = 3'd4,
        S_ABS2  = 3'd5,
        S_MEM   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  p_q, p_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  adl_q, adl_d;
    logic [7:0]  adh_q, adh_d;

    logic [2:0]  op;
    logic [7:0]  m_eff;
    logic [8:0]  sum;
    logic [8:0]  diff;
    logic [7:0]  res;
    logic        res_wr;
    logic [7:0]  alu_a;
    logic [7:0]  alu_p;
    logic        exec_en;

    assign op = ir_q[7:5];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            a_q     <= RESET_A;
            p_q     <= RESET_P | 8'h20;
            ir_q    <= 8'h00;
            adl_q   <= 8'h00;
            adh_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            p_q     <= p_d;
            ir_q    <= ir_d;
            adl_q   <= adl_d;
            adh_q   <= adh_d;
        end
    end

    // Next state; STA # (89) has no immediate form and falls to IMPL
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = S_IMPL;
                if (bus.d_in[1:0] == 2'b01) begin
                    case (bus.d_in[4:2])
                        3'b010:  state_d = (bus.d_in == 8'h89) ? S_IMPL : S_IMM;
                        3'b001:  state_d = S_ZP1;
                        3'b011:  state_d = S_ABS1;
                        default: state_d = S_IMPL;
                    endcase
                end
            end
            S_ZP1:   state_d = S_MEM;
            S_ABS1:  state_d = S_ABS2;
            S_ABS2:  state_d = S_MEM;
            default: state_d = S_FETCH;
        endcase
    end

    // ALU: binary arithmetic only; SBC is ADC with the operand inverted
    always_comb begin
        m_eff  = (op == OP_SBC) ? ~bus.d_in : bus.d_in;
        sum    = {1'b0, a_q} + {1'b0, m_eff} + 9'(p_q[P_C]);
        diff   = {1'b0, a_q} - {1'b0, bus.d_in};
        res    = a_q;
        res_wr = 1'b0;
        alu_p  = p_q;
        case (op)
            OP_ORA: begin res = a_q | bus.d_in; res_wr = 1'b1; end
            OP_AND: begin res = a_q & bus.d_in; res_wr = 1'b1; end
            OP_EOR: begin res = a_q ^ bus.d_in; res_wr = 1'b1; end
            OP_LDA: begin res = bus.d_in;       res_wr = 1'b1; end
            OP_ADC, OP_SBC: begin
                res        = sum[7:0];
                res_wr     = 1'b1;
                alu_p[P_C] = sum[8];
                alu_p[P_V] = (a_q[7] == m_eff[7]) && (sum[7] != a_q[7]);
            end
            OP_CMP: begin
                alu_p[P_C] = ~diff[8];
                alu_p[P_N] = diff[7];
                alu_p[P_Z] = (diff[7:0] == 8'h00);
            end
            default: ;
        endcase
        if (res_wr) begin
            alu_p[P_N] = res[7];
            alu_p[P_Z] = (res == 8'h00);
        end
        alu_a = res;
    end

    // Per-state bus outputs and register updates
    always_comb begin
        pc_d     = pc_q;
        a_d      = a_q;
        p_d      = p_q;
        ir_d     = ir_q;
        adl_d    = adl_q;
        adh_d    = adh_q;
        exec_en  = 1'b0;
        bus.addr = pc_q;
        bus.sync = 1'b0;
        bus.we   = 1'b0;
        bus.d_out = 8'h00;
        case (state_q)
            S_FETCH: begin
                bus.sync = 1'b1;
                ir_d     = bus.d_in;
                pc_d     = pc_q + 16'd1;
            end
            S_IMPL: begin
                if (ir_q == 8'h18) p_d[P_C] = 1'b0;
                if (ir_q == 8'h38) p_d[P_C] = 1'b1;
            end
            S_IMM: begin
                pc_d    = pc_q + 16'd1;
                exec_en = 1'b1;
            end
            S_ZP1: begin
                adl_d = bus.d_in;
                adh_d = 8'h00;
                pc_d  = pc_q + 16'd1;
            end
            S_ABS1: begin
                adl_d = bus.d_in;
                pc_d  = pc_q + 16'd1;
            end
            S_ABS2: begin
                adh_d = bus.d_in;
                pc_d  = pc_q + 16'd1;
            end
            S_MEM: begin
                bus.addr = {adh_q, adl_q};
                if (op == OP_STA) begin
                    bus.we    = 1'b1;
                    bus.d_out = a_q;
                end else begin
                    exec_en = 1'b1;
                end
            end
            default: ;
        endcase
        if (exec_en) begin
            a_d = alu_a;
            p_d = alu_p;
        end
        if (rst) begin
            bus.we    = 1'b0;
            bus.d_out = 8'h00;
        end
    end

    assign bus.a_out = a_q;
    assign bus.p_out = p_q;
endmodule

// File: tb/tb_cpu_grp1_core.sv
// Scoreboard bench for cpu_grp1_core: an instruction-level model predicts every bus cycle.
module tb_cpu_grp1_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst1;

    cpu_grp1_core_if bus0 ();
    cpu_grp1_core_if bus1 ();

    cpu_grp1_core #(.RESET_PC(16'h0200), .RESET_P(8'h24), .RESET_A(8'h00)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    cpu_grp1_core #(.RESET_PC(16'hFFFE), .RESET_P(8'hC3), .RESET_A(8'h5A)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1)
    );

    // Main memory for dut0; the bench loads it through the poke port while dut0 is in reset
    logic [7:0]  mem [0:65535];
    logic        poke_en;
    logic [15:0] poke_addr;
    logic [7:0]  poke_data;

    assign bus0.d_in = mem[bus0.addr];

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] = poke_data;
        else if (bus0.we) mem[bus0.addr] = bus0.d_out;
    end

    // Fixed ROM for dut1: LDA $1234 straddling the FFFF->0000 wrap
    always_comb begin
        case (bus1.addr)
            16'hFFFE: bus1.d_in = 8'hAD;
            16'hFFFF: bus1.d_in = 8'h34;
            16'h0000: bus1.d_in = 8'h12;
            16'h1234: bus1.d_in = 8'h99;
            default:  bus1.d_in = 8'hEA;
        endcase
    end

    typedef struct {
        int addr;
        int sync;
        int we;
        int dout;
        int a;
        int p;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [7:0]  mdl_mem [0:65535];
    int          m_pc, m_a, m_p;
    int          prog_q[$];
    int          prog_end;
    int          n_tests, n_fail;
    bit          mon_en;
    string       cur_name;

    function automatic void push_cyc(int addr, int sync, int we, int dout);
        cyc_t c;
        c.addr = addr & 'hFFFF;
        c.sync = sync;
        c.we   = we;
        c.dout = dout;
        c.a    = m_a;
        c.p    = m_p;
        exp_q.push_back(c);
    endfunction

    function automatic void set_flag(int bitpos, bit val);
        if (val) m_p = m_p | (1 << bitpos);
        else     m_p = m_p & ~(1 << bitpos);
    endfunction

    function automatic void set_nz(int r);
        set_flag(7, r >= 128);
        set_flag(1, r == 0);
    endfunction

    // Arithmetic done on plain integers, overflow from the signed-range definition
    function automatic void execute(int aaa, int m);
        int r, s, mm, sa, sm, c, ss;
        c = m_p & 1;
        case (aaa)
            0: begin r = m_a | m; set_nz(r); m_a = r; end
            1: begin r = m_a & m; set_nz(r); m_a = r; end
            2: begin r = m_a ^ m; set_nz(r); m_a = r; end
            5: begin r = m;       set_nz(r); m_a = r; end
            3, 7: begin
                mm = (aaa == 7) ? 255 - m : m;
                s  = m_a + mm + c;
                r  = s % 256;
                sa = (m_a >= 128) ? m_a - 256 : m_a;
                sm = (mm >= 128) ? mm - 256 : mm;
                ss = sa + sm + c;
                set_flag(0, s > 255);
                set_flag(6, (ss > 127) || (ss < -128));
                set_nz(r);
                m_a = r;
            end
            6: begin
                set_flag(0, m_a >= m);
                set_flag(7, ((m_a - m) & 255) >= 128);
                set_flag(1, m_a == m);
            end
            default: ;
        endcase
    endfunction

    // One instruction: push the expected bus activity of every cycle, then update state
    function automatic void model_step();
        int op, pc, ea, cc, bbb, aaa;
        op  = int'(mdl_mem[m_pc]);
        cc  = op % 4;
        bbb = (op / 4) % 8;
        aaa = op / 32;
        push_cyc(m_pc, 1, 0, 0);
        pc = (m_pc + 1) & 'hFFFF;
        if (cc == 1 && bbb == 2 && op != 'h89) begin
            push_cyc(pc, 0, 0, 0);
            execute(aaa, int'(mdl_mem[pc]));
            pc = (pc + 1) & 'hFFFF;
        end else if (cc == 1 && (bbb == 1 || bbb == 3)) begin
            push_cyc(pc, 0, 0, 0);
            ea = int'(mdl_mem[pc]);
            pc = (pc + 1) & 'hFFFF;
            if (bbb == 3) begin
                push_cyc(pc, 0, 0, 0);
                ea = ea + 256 * int'(mdl_mem[pc]);
                pc = (pc + 1) & 'hFFFF;
            end
            if (aaa == 4) begin
                push_cyc(ea, 0, 1, m_a);
                mdl_mem[ea] = 8'(m_a);
            end else begin
                push_cyc(ea, 0, 0, 0);
                execute(aaa, int'(mdl_mem[ea]));
            end
        end else begin
            push_cyc(pc, 0, 0, 0);
            if (op == 'h18) set_flag(0, 1'b0);
            if (op == 'h38) set_flag(0, 1'b1);
        end
        m_pc = pc;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic monitor();
        cyc_t e;
        forever begin
            @(negedge clk);
            if (mon_en && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (bus0.addr !== 16'(e.addr) || bus0.sync !== 1'(e.sync) ||
                    bus0.we !== 1'(e.we) || (e.we != 0 && bus0.d_out !== 8'(e.dout)) ||
                    bus0.a_out !== 8'(e.a) || bus0.p_out !== 8'(e.p)) begin
                    n_fail++;
                    $display("FAIL cycle %s: addr=%h sync=%b we=%b d_out=%h a=%h p=%h, expected addr=%h sync=%0d we=%0d d_out=%h a=%h p=%h",
                             cur_name, bus0.addr, bus0.sync, bus0.we, bus0.d_out, bus0.a_out, bus0.p_out,
                             16'(e.addr), e.sync, e.we, 8'(e.dout), 8'(e.a), 8'(e.p));
                end
            end
        end
    endtask

    task automatic poke(input int a, input int d);
        poke_addr  = 16'(a);
        poke_data  = 8'(d);
        poke_en    = 1'b1;
        mdl_mem[a] = 8'(d);
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic load_and_run(input string name);
        cur_name = name;
        rst = 1'b1;
        for (int i = 0; i < prog_q.size(); i++) poke('h200 + i, prog_q[i]);
        prog_end = 'h200 + prog_q.size();
        for (int k = 0; k < 4; k++) poke(prog_end + k, 'hEA);
        m_pc = 'h200;
        m_a  = 0;
        m_p  = 'h24;
        exp_q.delete();
        for (int g = 0; g < 10000 && m_pc != prog_end; g++) model_step();
        model_step();
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        mon_en = 1'b0;
        rst    = 1'b1;
        check({"drain ", name}, exp_q.size(), 0);
    endtask

    task automatic gen_random_prog(input int n);
        int kind, aaa, op;
        prog_q.delete();
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom_range(0, 9));
            aaa  = int'($urandom_range(0, 7));
            case (kind)
                0, 1, 2: begin
                    op = aaa * 32 + 8 + 1;
                    prog_q.push_back(op);
                    if (op != 'h89) prog_q.push_back(int'($urandom_range(0, 255)));
                end
                3, 4: begin
                    prog_q.push_back(aaa * 32 + 4 + 1);
                    prog_q.push_back(int'($urandom_range(0, 255)));
                end
                5, 6: begin
                    prog_q.push_back(aaa * 32 + 12 + 1);
                    prog_q.push_back(int'($urandom_range(0, 255)));
                    prog_q.push_back('h80);
                end
                7: prog_q.push_back(($urandom_range(0, 1) != 0) ? 'h38 : 'h18);
                8: begin
                    op = int'($urandom_range(0, 255));
                    if (op % 4 == 1) op = op ^ 1;
                    prog_q.push_back(op);
                end
                default: prog_q.push_back(($urandom_range(0, 1) != 0) ? 'hEA : 'h89);
            endcase
        end
    endtask

    int exp1_addr[5] = '{'hFFFE, 'hFFFF, 'h0000, 'h1234, 'h0001};
    int exp1_sync[5] = '{1, 0, 0, 0, 1};
    int exp1_a[5]    = '{'h5A, 'h5A, 'h5A, 'h5A, 'h99};
    int exp1_p[5]    = '{'hE3, 'hE3, 'hE3, 'hE3, 'hE1};

    initial begin
        int bad;
        rst       = 1'b1;
        rst1      = 1'b1;
        poke_en   = 1'b0;
        poke_addr = 16'h0000;
        poke_data = 8'h00;
        mon_en    = 1'b0;
        n_tests   = 0;
        n_fail    = 0;
        cur_name  = "init";
        fork
            monitor();
        join_none

        for (int a = 0; a < 256; a++) poke(a, int'($urandom_range(0, 255)));
        for (int a = 'h8000; a < 'h8100; a++) poke(a, int'($urandom_range(0, 255)));

        prog_q = '{'hA9, 'h05, 'h69, 'h03};
        load_and_run("lda_adc");
        prog_q = '{'hA9, 'h7F, 'h18, 'h69, 'h01, 'h38, 'hE9, 'h80};
        load_and_run("adc_sbc_ovf");
        prog_q = '{'hA9, 'h42, 'h85, 'h10, 'hAD, 'h10, 'h00};
        load_and_run("sta_zp_lda_abs");
        prog_q = '{'hA9, 'h10, 'hC9, 'h20, 'hC9, 'h10};
        load_and_run("cmp");
        prog_q = '{'hA9, 'h33, 'h89, 'hEA, 'h38, 'h89, 'hEA, 'h18};
        load_and_run("nops");

        for (int r = 0; r < 3; r++) begin
            gen_random_prog(80);
            load_and_run($sformatf("random%0d", r));
        end

        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== mdl_mem[a]) bad++;
        for (int a = 'h8000; a < 'h8100; a++) if (mem[a] !== mdl_mem[a]) bad++;
        check("mem_final", bad, 0);

        // Reset during ABS2 of STA $8034
        prog_q = '{'hA9, 'h77, 'h8D, 'h34, 'h80};
        for (int i = 0; i < prog_q.size(); i++) poke('h200 + i, prog_q[i]);
        poke('h8034, 'h11);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abs2_addr", int'(bus0.addr), 'h0204);
        check("abs2_rst_we", int'(bus0.we), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_addr", int'(bus0.addr), 'h0200);
        check("post_rst_sync", int'(bus0.sync), 1);
        check("post_rst_a", int'(bus0.a_out), 'h00);
        check("post_rst_p", int'(bus0.p_out), 'h24);
        @(posedge clk);
        #1 rst = 1'b1;
        check("abs2_rst_nowrite", int'(mem['h8034]), 'h11);

        // Reset during the MEM cycle itself: strobe and data forced low
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mem_rst_addr", int'(bus0.addr), 'h8034);
        check("mem_rst_a", int'(bus0.a_out), 'h77);
        check("mem_rst_we", int'(bus0.we), 0);
        check("mem_rst_dout", int'(bus0.d_out), 0);
        @(posedge clk);
        #1;
        check("mem_rst_nowrite", int'(mem['h8034]), 'h11);
        @(negedge clk);
        check("mem_rst_a_after", int'(bus0.a_out), 'h00);

        // Second core: parametrised reset state and operand wrap at FFFF
        @(posedge clk);
        #1 rst1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("wrap_addr%0d", i), int'(bus1.addr), exp1_addr[i]);
            check($sformatf("wrap_sync%0d", i), int'(bus1.sync), exp1_sync[i]);
            check($sformatf("wrap_a%0d", i), int'(bus1.a_out), exp1_a[i]);
            check($sformatf("wrap_p%0d", i), int'(bus1.p_out), exp1_p[i]);
            check($sformatf("wrap_we%0d", i), int'(bus1.we), 0);
        end
        rst1 = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_grp1_core.md
Name: cpu_grp1_core

Overview:
- Multi-cycle 6502-style execution core for the full cc=01 instruction group: ORA, AND, EOR, ADC, STA, LDA, CMP, SBC.
- Supports three addressing modes: immediate, zero page and absolute. Also supports CLC/SEC; every other opcode executes as a 2-cycle NOP.
- Sits between the program/data memory (combinational read, clocked write) and the debug/trace logic.
- Successor to the single-mode accumulator datapath: adds real addressing-mode sequencing, stores, a complete flag set and a parametrised reset state.

Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- RESET_P, 8'h24: processor status on reset. Bit order N V 1 B D I Z C (bit 7..0).
- RESET_A, 8'h00: accumulator on reset.

Ports:
- clk, input, 1: single clock; all state changes on posedge.
- rst, input, 1: synchronous, active-high reset.
- d_in, input, 8: memory read data. Combinational function of addr in the same cycle; sampled at posedge.
- d_out, output, 8: memory write data. Valid only when we=1.
- addr, output, 16: memory address.
- we, output, 1: write strobe. Memory writes d_out to addr at the posedge ending the cycle.
- sync, output, 1: high in the opcode-fetch cycle.
- a_out, output, 8: accumulator, for trace.
- p_out, output, 8: status register; bit 5 is always 1.

Behaviour:

Reset (rst sampled high at posedge):
- state=FETCH, PC=RESET_PC, A=RESET_A, P=RESET_P|8'h20, IR=00, ADL=ADH=00.
- While rst is high: we=0 and d_out=00, regardless of state.
- Reset asserted mid-instruction abandons the instruction. No register or memory update occurs from that instruction.

States and per-cycle actions (addr is combinational from state):
- FETCH
  - addr=PC, sync=1. IR<=d_in, PC<=PC+1.
  - Next state by the fetched byte:
    - cc=01, bbb=010, except 8'h89 (STA #) -> IMM
    - cc=01, bbb=001 -> ZP1
    - cc=01, bbb=011 -> ABS1
    - anything else, including 8'h89 -> IMPL
- IMPL
  - addr=PC, dummy read, no PC increment.
  - 8'h18 clears C; 8'h38 sets C; all others leave state unchanged.
  - Next: FETCH.
- IMM
  - addr=PC, M=d_in, PC<=PC+1, execute.
  - Next: FETCH.
- ZP1
  - addr=PC, ADL<=d_in, ADH<=00, PC<=PC+1.
  - Next: MEM.
- ABS1
  - addr=PC, ADL<=d_in, PC<=PC+1.
  - Next: ABS2.
- ABS2
  - addr=PC, ADH<=d_in, PC<=PC+1.
  - Next: MEM.
- MEM
  - addr={ADH,ADL}.
  - STA: we=1, d_out=A; no flag change.
  - Otherwise: M=d_in, execute.
  - Next: FETCH.

Instruction latency:
- IMM: 2 cycles. ZP: 3 cycles. ABS: 4 cycles. IMPL/NOP: 2 cycles.
- Results (A, P) are visible on a_out/p_out in the cycle after the execute edge. That cycle is the next FETCH.

Execute semantics (8-bit; D flag ignored, binary arithmetic only):
- ORA / AND / EOR / LDA: A <= A|M, A&M, A^M, M respectively. N, Z set from the result.
- ADC:
  - sum = A + M + C, computed 9 bits wide. A <= sum[7:0], C <= sum[8].
  - V <= (A[7]==M[7]) && (sum[7]!=A[7]).
  - N, Z from sum[7:0].
- SBC: identical to ADC with M replaced by ~M.
- CMP: r = A - M. C <= (A>=M) unsigned; N <= r[7]; Z <= (r==0). A unchanged; V unchanged.
- Flags not listed for an instruction are unchanged.

Boundaries:
- PC wraps 16'hFFFF -> 16'h0000.
- Zero-page effective address is always 16'h00xx.
- An operand fetch at 16'hFFFF wraps to 16'h0000 for the next byte.
- we is asserted only in MEM for STA; it is never asserted in any other state.

Test Plan:
- Reset with RESET_PC=16'h0200, mem[0200..]=A9 05 69 03:
  - addr=0200 and sync=1 after reset.
  - After 4 cycles, A=08, C=0, Z=0, N=0.
  - sync is high at exactly cycles 0 and 2.
- C=0, A=7F, ADC #01 -> A=80, V=1, N=1, C=0.
  - Then SEC (38), SBC #80 (E9 80) -> A=00, Z=1, C=1, V=0.
- A=42, STA $10 (85 10):
  - Exactly one cycle with we=1, addr=0010, d_out=42, at cycle 3 of the instruction.
  - Then LDA $0010 (AD 10 00) -> 4 cycles; A=42; addr sequence PC, PC+1, PC+2, 0010.
- A=10, CMP #20 (C9 20) -> C=0, N=1, Z=0, A=10. CMP #10 -> C=1, Z=1.
- Opcode 89 and opcode EA:
  - Each takes 2 cycles with PC advancing by 1.
  - A, P and memory unchanged; we never asserted.
- Instruction at PC=FFFE, AD 34 12 (operand wraps):
  - Operand bytes read from FFFF and 0000.
  - Effective addr=1234 in MEM.
  - PC=0001 at the next FETCH.
- Reset asserted during the ABS2 cycle of STA abs:
  - we stays 0 and no write occurs.
  - Next cycle: addr=RESET_PC, A=RESET_A, p_out=RESET_P.
